fetch_pc: RTL

FETCH_PC -- requirements
Module: fetch_pc

---
 rtl/fetch_pc_pkg.sv | 34 +++
 rtl/fetch_pc_branch_lut.sv | 16 +
 rtl/fetch_pc.sv | 114 +++++++++++
 3 files changed

// File: rtl/fetch_pc_pkg.sv
// Shared definitions for the fetch/PC block: default widths, state encoding
// and the fixed branch-offset table contents.
package definitionsABC;

    localparam int PC_W_DEF   = 10;
    localparam int LUT_AW_DEF = 5;
    localparam int CYC_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_st_t;

    // Signed branch offsets; entries past the hand-picked ones fall back to idx-16.
    function automatic int lut_offset(input int idx);
        case (idx)
            0:       return 0;
            1:       return 1;
            2:       return 2;
            3:       return -4;
            4:       return -5;
            5:       return 8;
            6:       return 16;
            7:       return -16;
            8:       return 100;
            9:       return -100;
            10:      return 3;
            11:      return -1;
            default: return idx - 16;
        endcase
    endfunction

endpackage

// File: rtl/fetch_pc_branch_lut.sv
// Combinational branch-offset table, contents fixed at elaboration.
module branch_lut
    import definitionsABC::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int LUT_AW = LUT_AW_DEF
) (
    input  logic        [LUT_AW-1:0] idx,
    output logic signed [PC_W-1:0]   offset
);

    always_comb begin
        offset = PC_W'(lut_offset(int'(idx)));
    end

endmodule

// File: rtl/fetch_pc.sv
// Program-counter / fetch sequencer: IDLE -> RUN -> HALT with branch LUT,
// shift/carry register and a saturating executed-cycle counter.
module fetch_pc
    import definitionsABC::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int LUT_AW = LUT_AW_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stall,
    input  logic              Br_en,
    input  logic [LUT_AW-1:0] Br_idx,
    input  logic              BR_FLAG,
    input  logic              Halt,
    input  logic              SC_OUT,
    input  logic              SC_we,
    input  logic              SC_clr,
    output logic [PC_W-1:0]   PC,
    output logic              SC_IN,
    output logic              Done,
    output logic [CYC_W-1:0]  Cycles
);

    fetch_st_t          state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               sc_q, sc_d;
    logic [CYC_W-1:0]   cycles_q, cycles_d;
    logic               start_prev_q, start_prev_d;
    logic signed [PC_W-1:0] lut_off;

    branch_lut #(
        .PC_W   (PC_W),
        .LUT_AW (LUT_AW)
    ) u_branch_lut (
        .idx    (Br_idx),
        .offset (lut_off)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        sc_d         = sc_q;
        cycles_d     = cycles_q;
        start_prev_d = Start;

        case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                sc_d = 1'b0;
                // Launch only on a genuine high-to-low edge of Start.
                if (!Start && start_prev_q) begin
                    state_d  = ST_RUN;
                    cycles_d = '0;
                end
            end
            ST_RUN: begin
                if (Start) begin
                    state_d = ST_IDLE;
                    pc_d    = '0;
                    sc_d    = 1'b0;
                end else if (!Stall) begin
                    cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + CYC_W'(1);
                    if (SC_clr)
                        sc_d = 1'b0;
                    else if (SC_we)
                        sc_d = SC_OUT;
                    if (Halt)
                        state_d = ST_HALT;
                    else if (Br_en && BR_FLAG)
                        pc_d = pc_q + lut_off;
                    else
                        pc_d = pc_q + PC_W'(1);
                end
            end
            ST_HALT: begin
                if (Start) begin
                    state_d = ST_IDLE;
                    pc_d    = '0;
                    sc_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
                sc_d    = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            sc_q         <= 1'b0;
            cycles_q     <= '0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            sc_q         <= sc_d;
            cycles_q     <= cycles_d;
            start_prev_q <= start_prev_d;
        end
    end

    assign PC     = pc_q;
    assign SC_IN  = sc_q;
    assign Done   = (state_q == ST_HALT);
    assign Cycles = cycles_q;

endmodule
